// File: rtl/can_rx_frame.sv
// CAN 2.0A/2.0B frame receiver: hard sync on SOF, destuffing, field decode,
// CRC-15/stuff/form checking, one parallel frame record per good frame.
module can_rx_frame #(
  parameter int CLKS_PER_BIT = 10,
  parameter int SAMPLE_PT    = 7,
  parameter bit EXT_ID_EN    = 1'b1
) (
  input  logic        i_Clock,
  input  logic        i_Reset_n,
  input  logic        i_Rx_Serial,
  output logic        o_Rx_DV,
  output logic [28:0] o_Rx_Id,
  output logic        o_Rx_Ide,
  output logic        o_Rx_Rtr,
  output logic [3:0]  o_Rx_Dlc,
  output logic [63:0] o_Rx_Data,
  output logic        o_Rx_Err,
  output logic [2:0]  o_Rx_Err_Code,
  output logic        o_Busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  typedef enum logic [4:0] {
    S_INTEGRATE, S_IDLE, S_SOF, S_ID_A, S_RTR_A, S_IDE, S_ID_B, S_RTR_B,
    S_R1, S_R0, S_DLC, S_DATA, S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF
  } state_t;

  state_t        state_q, state_d;
  logic          rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    integ_q, integ_d;
  logic [2:0]    run_q, run_d;
  logic          prev_q, prev_d;
  logic [5:0]    fcnt_q, fcnt_d;
  logic [28:0]   id_q, id_d;
  logic          rtr_q, rtr_d, ide_q, ide_d;
  logic [3:0]    dlc_q, dlc_d;
  logic [63:0]   data_q, data_d;
  logic [14:0]   crc_q, crc_d, crc_rx_q, crc_rx_d;
  logic          crc_err_q, crc_err_d;
  logic          dv_q, dv_d, err_q, err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic [28:0]   out_id_q, out_id_d;
  logic          out_ide_q, out_ide_d, out_rtr_q, out_rtr_d;
  logic [3:0]    out_dlc_q, out_dlc_d;
  logic [63:0]   out_data_q, out_data_d;
  logic          busy_q, busy_d;

  logic          sample, sample_en, stuff_region;
  logic [3:0]    dlc_full, data_bytes;
  logic [6:0]    data_last;
  logic [5:0]    data_pos;

  function automatic logic [14:0] crc_next(input logic [14:0] c, input logic b);
    logic fb;
    fb = b ^ c[14];
    return {c[13:0], 1'b0} ^ (fb ? 15'h4599 : 15'h0000);
  endfunction

  always_comb begin
    state_d    = state_q;
    rx_meta_d  = i_Rx_Serial;
    rx_sync_d  = rx_meta_q;
    cnt_d      = (cnt_q == CW'(CLKS_PER_BIT - 1)) ? '0 : cnt_q + 1'b1;
    integ_d    = integ_q;
    run_d      = run_q;
    prev_d     = prev_q;
    fcnt_d     = fcnt_q;
    id_d       = id_q;
    rtr_d      = rtr_q;
    ide_d      = ide_q;
    dlc_d      = dlc_q;
    data_d     = data_q;
    crc_d      = crc_q;
    crc_rx_d   = crc_rx_q;
    crc_err_d  = crc_err_q;
    dv_d       = 1'b0;
    err_d      = 1'b0;
    err_code_d = 3'b000;
    out_id_d   = out_id_q;
    out_ide_d  = out_ide_q;
    out_rtr_d  = out_rtr_q;
    out_dlc_d  = out_dlc_q;
    out_data_d = out_data_q;

    sample       = rx_sync_q;
    sample_en    = (cnt_q == CW'(SAMPLE_PT));
    // A stuff bit may still follow the last CRC bit, so it is consumed in CRC_DEL.
    stuff_region = (state_q inside {S_ID_A, S_RTR_A, S_IDE, S_ID_B, S_RTR_B, S_R1,
                                    S_R0, S_DLC, S_DATA, S_CRC})
                   || (state_q == S_CRC_DEL && run_q == 3'd5);
    dlc_full     = {dlc_q[2:0], sample};
    data_bytes   = dlc_q[3] ? 4'd8 : {1'b0, dlc_q[2:0]};
    data_last    = {data_bytes, 3'b111} - 7'd8;
    data_pos     = {fcnt_q[5:3], ~fcnt_q[2:0]};

    case (state_q)
      S_INTEGRATE: begin
        if (sample_en) begin
          if (!sample) begin
            integ_d = '0;
          end else if (integ_q == 4'd10) begin
            integ_d = '0;
            state_d = S_IDLE;
          end else begin
            integ_d = integ_q + 4'd1;
          end
        end
      end
      S_IDLE: begin
        if (!rx_sync_q) begin
          cnt_d     = '0;
          state_d   = S_SOF;
          fcnt_d    = '0;
          id_d      = '0;
          rtr_d     = 1'b0;
          ide_d     = 1'b0;
          dlc_d     = '0;
          data_d    = '0;
          crc_d     = '0;
          crc_rx_d  = '0;
          crc_err_d = 1'b0;
        end
      end
      default: begin
        if (sample_en) begin
          if (state_q == S_SOF) begin
            if (sample) begin
              state_d = S_IDLE;
            end else begin
              run_d   = 3'd1;
              prev_d  = 1'b0;
              crc_d   = crc_next(crc_q, 1'b0);
              fcnt_d  = '0;
              state_d = S_ID_A;
            end
          end else if (stuff_region && run_q == 3'd5) begin
            if (sample == prev_q) begin
              err_d      = 1'b1;
              err_code_d = 3'b010;
              integ_d    = '0;
              state_d    = S_INTEGRATE;
            end else begin
              prev_d = sample;
              run_d  = 3'd1;
            end
          end else begin
            if (stuff_region) begin
              run_d  = (sample == prev_q) ? run_q + 3'd1 : 3'd1;
              prev_d = sample;
            end
            if (state_q inside {S_ID_A, S_RTR_A, S_IDE, S_ID_B, S_RTR_B, S_R1,
                                S_R0, S_DLC, S_DATA}) begin
              crc_d = crc_next(crc_q, sample);
            end
            case (state_q)
              S_ID_A: begin
                id_d   = {id_q[27:0], sample};
                fcnt_d = fcnt_q + 6'd1;
                if (fcnt_q == 6'd10) state_d = S_RTR_A;
              end
              S_RTR_A: begin
                rtr_d   = sample;
                state_d = S_IDE;
              end
              S_IDE: begin
                ide_d  = sample;
                fcnt_d = '0;
                if (!sample) begin
                  state_d = S_R0;
                end else if (EXT_ID_EN) begin
                  state_d = S_ID_B;
                end else begin
                  integ_d = '0;
                  state_d = S_INTEGRATE;
                end
              end
              S_ID_B: begin
                id_d   = {id_q[27:0], sample};
                fcnt_d = fcnt_q + 6'd1;
                if (fcnt_q == 6'd17) state_d = S_RTR_B;
              end
              S_RTR_B: begin
                rtr_d   = sample;
                state_d = S_R1;
              end
              S_R1: state_d = S_R0;
              S_R0: begin
                fcnt_d  = '0;
                state_d = S_DLC;
              end
              S_DLC: begin
                dlc_d  = dlc_full;
                fcnt_d = fcnt_q + 6'd1;
                if (fcnt_q == 6'd3) begin
                  fcnt_d  = '0;
                  state_d = (rtr_q || dlc_full == 4'd0) ? S_CRC : S_DATA;
                end
              end
              S_DATA: begin
                data_d[data_pos] = sample;
                fcnt_d = fcnt_q + 6'd1;
                if ({1'b0, fcnt_q} == data_last) begin
                  fcnt_d  = '0;
                  state_d = S_CRC;
                end
              end
              S_CRC: begin
                crc_rx_d = {crc_rx_q[13:0], sample};
                fcnt_d   = fcnt_q + 6'd1;
                if (fcnt_q == 6'd14) state_d = S_CRC_DEL;
              end
              S_CRC_DEL: begin
                crc_err_d = (crc_rx_q != crc_q);
                if (!sample) begin
                  err_d      = 1'b1;
                  err_code_d = 3'b001;
                  integ_d    = '0;
                  state_d    = S_INTEGRATE;
                end else begin
                  state_d = S_ACK;
                end
              end
              S_ACK: state_d = S_ACK_DEL;
              S_ACK_DEL: begin
                fcnt_d = '0;
                if (!sample) begin
                  err_d      = 1'b1;
                  err_code_d = 3'b001;
                  integ_d    = '0;
                  state_d    = S_INTEGRATE;
                end else begin
                  state_d = S_EOF;
                end
              end
              S_EOF: begin
                fcnt_d = fcnt_q + 6'd1;
                if (!sample) begin
                  err_d      = 1'b1;
                  err_code_d = 3'b001;
                  integ_d    = '0;
                  state_d    = S_INTEGRATE;
                end else if (fcnt_q == 6'd6) begin
                  state_d = S_IDLE;
                  if (crc_err_q) begin
                    err_d      = 1'b1;
                    err_code_d = 3'b100;
                  end else begin
                    dv_d       = 1'b1;
                    out_id_d   = id_q;
                    out_ide_d  = ide_q;
                    out_rtr_d  = rtr_q;
                    out_dlc_d  = dlc_q;
                    out_data_d = data_q;
                  end
                end
              end
              default: state_d = S_INTEGRATE;
            endcase
          end
        end
      end
    endcase

    busy_d = !(state_d inside {S_INTEGRATE, S_IDLE}) || dv_d || err_d;
  end

  always_ff @(posedge i_Clock) begin
    if (!i_Reset_n) begin
      state_q    <= S_INTEGRATE;
      rx_meta_q  <= 1'b1;
      rx_sync_q  <= 1'b1;
      cnt_q      <= '0;
      integ_q    <= '0;
      run_q      <= '0;
      prev_q     <= 1'b1;
      fcnt_q     <= '0;
      id_q       <= '0;
      rtr_q      <= 1'b0;
      ide_q      <= 1'b0;
      dlc_q      <= '0;
      data_q     <= '0;
      crc_q      <= '0;
      crc_rx_q   <= '0;
      crc_err_q  <= 1'b0;
      dv_q       <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= '0;
      out_id_q   <= '0;
      out_ide_q  <= 1'b0;
      out_rtr_q  <= 1'b0;
      out_dlc_q  <= '0;
      out_data_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rx_meta_q  <= rx_meta_d;
      rx_sync_q  <= rx_sync_d;
      cnt_q      <= cnt_d;
      integ_q    <= integ_d;
      run_q      <= run_d;
      prev_q     <= prev_d;
      fcnt_q     <= fcnt_d;
      id_q       <= id_d;
      rtr_q      <= rtr_d;
      ide_q      <= ide_d;
      dlc_q      <= dlc_d;
      data_q     <= data_d;
      crc_q      <= crc_d;
      crc_rx_q   <= crc_rx_d;
      crc_err_q  <= crc_err_d;
      dv_q       <= dv_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      out_id_q   <= out_id_d;
      out_ide_q  <= out_ide_d;
      out_rtr_q  <= out_rtr_d;
      out_dlc_q  <= out_dlc_d;
      out_data_q <= out_data_d;
      busy_q     <= busy_d;
    end
  end

  assign o_Rx_DV       = dv_q;
  assign o_Rx_Err      = err_q;
  assign o_Rx_Err_Code = err_code_q;
  assign o_Rx_Id       = out_id_q;
  assign o_Rx_Ide      = out_ide_q;
  assign o_Rx_Rtr      = out_rtr_q;
  assign o_Rx_Dlc      = out_dlc_q;
  assign o_Rx_Data     = out_data_q;
  assign o_Busy        = busy_q;

endmodule

// File: tb/tb_can_rx_frame.sv
// Directed bench for can_rx_frame: builds stuffed CAN frames with their own
// CRC-15, drives them on the bus and checks the decoded records and errors.
module tb_can_rx_frame;

  localparam int CPB = 10;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx = 1'b1;

  logic        dv, err, ide, rtr, busy;
  logic [28:0] id;
  logic [3:0]  dlc;
  logic [63:0] data;
  logic [2:0]  errCode;

  logic        dv2, err2, ide2, rtr2, busy2;
  logic [28:0] id2;
  logic [3:0]  dlc2;
  logic [63:0] data2;
  logic [2:0]  errCode2;

  can_rx_frame #(.CLKS_PER_BIT(CPB), .SAMPLE_PT(7), .EXT_ID_EN(1'b1)) dut (
    .i_Clock(clk), .i_Reset_n(reset_n), .i_Rx_Serial(rx),
    .o_Rx_DV(dv), .o_Rx_Id(id), .o_Rx_Ide(ide), .o_Rx_Rtr(rtr),
    .o_Rx_Dlc(dlc), .o_Rx_Data(data), .o_Rx_Err(err),
    .o_Rx_Err_Code(errCode), .o_Busy(busy)
  );

  can_rx_frame #(.CLKS_PER_BIT(CPB), .SAMPLE_PT(7), .EXT_ID_EN(1'b0)) dutNoExt (
    .i_Clock(clk), .i_Reset_n(reset_n), .i_Rx_Serial(rx),
    .o_Rx_DV(dv2), .o_Rx_Id(id2), .o_Rx_Ide(ide2), .o_Rx_Rtr(rtr2),
    .o_Rx_Dlc(dlc2), .o_Rx_Data(data2), .o_Rx_Err(err2),
    .o_Rx_Err_Code(errCode2), .o_Busy(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int dvCount = 0, errCount = 0, bothCount = 0, dv2Count = 0, err2Count = 0;
  logic [2:0] lastErrCode = 3'b000;

  bit raw [0:255];
  int nraw;
  bit fb [0:511];
  int nbits;

  // Pulse monitor, sampled on the falling edge away from the DUT's active edge.
  always @(negedge clk) begin
    if (dv) dvCount <= dvCount + 1;
    if (err) begin
      errCount    <= errCount + 1;
      lastErrCode <= errCode;
    end
    if (dv && err) bothCount <= bothCount + 1;
    if (dv2) dv2Count <= dv2Count + 1;
    if (err2) err2Count <= err2Count + 1;
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks = checks + 1;
    if (got !== exp) begin
      failures = failures + 1;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [14:0] crcStep(input logic [14:0] c, input bit b);
    logic [14:0] r;
    r = {c[13:0], 1'b0};
    if (b != c[14]) r = r ^ 15'h4599;
    return r;
  endfunction

  task automatic pushRaw(input bit b);
    raw[nraw] = b;
    nraw = nraw + 1;
  endtask

  task automatic pushBit(input bit b);
    fb[nbits] = b;
    nbits = nbits + 1;
  endtask

  task automatic buildFrame(input bit fIde, input logic [28:0] fId, input bit fRtr,
                            input logic [3:0] fDlc, input logic [63:0] fData,
                            input int flipCrc, input bit crcDelDom, input int eofDom,
                            input bit skipStuff);
    logic [14:0] crc;
    int nbytes, run;
    bit prev, skipped;
    nraw = 0;
    pushRaw(1'b0);
    if (!fIde) begin
      for (int i = 10; i >= 0; i--) pushRaw(fId[i]);
      pushRaw(fRtr); pushRaw(1'b0); pushRaw(1'b0);
    end else begin
      for (int i = 28; i >= 18; i--) pushRaw(fId[i]);
      pushRaw(1'b1); pushRaw(1'b1);
      for (int i = 17; i >= 0; i--) pushRaw(fId[i]);
      pushRaw(fRtr); pushRaw(1'b0); pushRaw(1'b0);
    end
    for (int i = 3; i >= 0; i--) pushRaw(fDlc[i]);
    nbytes = fRtr ? 0 : ((fDlc > 4'd8) ? 8 : int'(fDlc));
    for (int k = 0; k < nbytes; k++)
      for (int b = 7; b >= 0; b--) pushRaw(fData[8*k + b]);
    crc = 15'h0000;
    for (int i = 0; i < nraw; i++) crc = crcStep(crc, raw[i]);
    if (flipCrc >= 0) crc[14 - flipCrc] = ~crc[14 - flipCrc];
    for (int i = 14; i >= 0; i--) pushRaw(crc[i]);
    // Stuff SOF..CRC; the transmitter model starts from a recessive bus.
    nbits = 0; run = 0; prev = 1'b1; skipped = 1'b0;
    for (int i = 0; i < nraw; i++) begin
      pushBit(raw[i]);
      if (raw[i] == prev) run = run + 1;
      else begin run = 1; prev = raw[i]; end
      if (run == 5) begin
        if (skipStuff && !skipped) skipped = 1'b1;
        else pushBit(~prev);
        run = 1;
        prev = ~prev;
      end
    end
    pushBit(~crcDelDom);
    pushBit(1'b0);
    pushBit(1'b1);
    for (int i = 0; i < 7; i++) pushBit((i == eofDom) ? 1'b0 : 1'b1);
  endtask

  task automatic driveBits(input int from, input int upto);
    for (int i = from; i < upto; i++) begin
      rx = fb[i];
      repeat (CPB) @(negedge clk);
    end
  endtask

  task automatic idleBits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic applyStimulus(input bit fIde, input logic [28:0] fId, input bit fRtr,
                               input logic [3:0] fDlc, input logic [63:0] fData,
                               input int flipCrc, input bit crcDelDom, input int eofDom,
                               input bit skipStuff);
    buildFrame(fIde, fId, fRtr, fDlc, fData, flipCrc, crcDelDom, eofDom, skipStuff);
    driveBits(0, nbits);
    idleBits(14);
  endtask

  int dv0, err0, dv20, err20;

  initial begin
    rx = 1'b1;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_dv", dv, 0);
    checkOutput("reset_err", err, 0);
    checkOutput("reset_busy", busy, 0);
    checkOutput("reset_id", id, 0);
    checkOutput("reset_data", data, 0);
    reset_n = 1'b1;
    idleBits(15);

    $display("[TB] standard data frame");
    dv0 = dvCount; err0 = errCount;
    applyStimulus(1'b0, 29'h123, 1'b0, 4'd2, 64'hCDAB, -1, 1'b0, -1, 1'b0);
    checkOutput("std_dv_count", dvCount - dv0, 1);
    checkOutput("std_err_count", errCount - err0, 0);
    checkOutput("std_id", id, 64'h123);
    checkOutput("std_ide", ide, 0);
    checkOutput("std_rtr", rtr, 0);
    checkOutput("std_dlc", dlc, 2);
    checkOutput("std_data", data, 64'h0000_0000_0000_CDAB);

    $display("[TB] extended remote frame");
    dv0 = dvCount; err0 = errCount; dv20 = dv2Count; err20 = err2Count;
    applyStimulus(1'b1, 29'h1ABCDE12, 1'b1, 4'd4, 64'h0, -1, 1'b0, -1, 1'b0);
    checkOutput("ext_dv_count", dvCount - dv0, 1);
    checkOutput("ext_err_count", errCount - err0, 0);
    checkOutput("ext_id", id, 64'h1ABCDE12);
    checkOutput("ext_ide", ide, 1);
    checkOutput("ext_rtr", rtr, 1);
    checkOutput("ext_dlc", dlc, 4);
    checkOutput("ext_data", data, 0);
    checkOutput("noext_dv_count", dv2Count - dv20, 0);
    checkOutput("noext_err_count", err2Count - err20, 0);

    $display("[TB] DLC 15 frame");
    dv0 = dvCount;
    applyStimulus(1'b0, 29'h2A5, 1'b0, 4'd15, 64'h0807060504030201, -1, 1'b0, -1, 1'b0);
    checkOutput("dlc15_dv_count", dvCount - dv0, 1);
    checkOutput("dlc15_dlc", dlc, 15);
    checkOutput("dlc15_data", data, 64'h0807060504030201);
    checkOutput("dlc15_id", id, 64'h2A5);

    $display("[TB] stuff error then recovery");
    dv0 = dvCount; err0 = errCount;
    applyStimulus(1'b0, 29'h010, 1'b0, 4'd1, 64'h55, -1, 1'b0, -1, 1'b1);
    checkOutput("stuff_err_count", errCount - err0, 1);
    checkOutput("stuff_code", lastErrCode, 3'b010);
    checkOutput("stuff_dv_count", dvCount - dv0, 0);
    dv0 = dvCount;
    applyStimulus(1'b0, 29'h456, 1'b0, 4'd1, 64'h5A, -1, 1'b0, -1, 1'b0);
    checkOutput("recover_dv_count", dvCount - dv0, 1);
    checkOutput("recover_id", id, 64'h456);
    checkOutput("recover_data", data, 64'h5A);

    $display("[TB] CRC and form errors");
    dv0 = dvCount; err0 = errCount;
    applyStimulus(1'b0, 29'h321, 1'b0, 4'd1, 64'h77, 3, 1'b0, -1, 1'b0);
    checkOutput("crc_err_count", errCount - err0, 1);
    checkOutput("crc_code", lastErrCode, 3'b100);
    checkOutput("crc_dv_count", dvCount - dv0, 0);
    err0 = errCount;
    applyStimulus(1'b0, 29'h321, 1'b0, 4'd1, 64'h77, -1, 1'b1, -1, 1'b0);
    checkOutput("crcdel_err_count", errCount - err0, 1);
    checkOutput("crcdel_code", lastErrCode, 3'b001);
    err0 = errCount;
    applyStimulus(1'b0, 29'h321, 1'b0, 4'd1, 64'h77, -1, 1'b0, 2, 1'b0);
    checkOutput("eof_err_count", errCount - err0, 1);
    checkOutput("eof_code", lastErrCode, 3'b001);
    checkOutput("form_dv_count", dvCount - dv0, 0);

    $display("[TB] reset during data");
    dv0 = dvCount; err0 = errCount;
    buildFrame(1'b0, 29'h123, 1'b0, 4'd2, 64'hCDAB, -1, 1'b0, -1, 1'b0);
    driveBits(0, 24);
    checkOutput("mid_busy", busy, 1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_id", id, 0);
    checkOutput("rst_data", data, 0);
    checkOutput("rst_dlc", dlc, 0);
    checkOutput("rst_flags", {dv, err, ide, rtr, errCode}, 0);
    rx = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    idleBits(5);
    driveBits(0, nbits);
    idleBits(14);
    checkOutput("short_idle_dv_count", dvCount - dv0, 0);
    checkOutput("short_idle_err_count", errCount - err0, 0);
    applyStimulus(1'b0, 29'h0F0, 1'b0, 4'd1, 64'hE1, -1, 1'b0, -1, 1'b0);
    checkOutput("long_idle_dv_count", dvCount - dv0, 1);
    checkOutput("long_idle_id", id, 64'h0F0);

    $display("[TB] glitch in idle");
    dv0 = dvCount; err0 = errCount;
    rx = 1'b0;
    repeat (3) @(negedge clk);
    idleBits(20);
    checkOutput("glitch_dv_count", dvCount - dv0, 0);
    checkOutput("glitch_err_count", errCount - err0, 0);
    checkOutput("dv_err_overlap", bothCount, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/can_rx_frame.md
Name: can_rx_frame

Overview:
- Parametrised CAN 2.0A/2.0B frame receiver; successor to the fixed-length 108-bit serial capture receiver.
- Recovers bit timing from a hard sync on SOF, removes stuff bits and decodes standard or extended frames field by field.
- Handles DLC-driven variable data length and RTR frames, and checks CRC-15, stuffing and fixed-form bits.
- Sits between the bus pin (after the transceiver) and the frame-consuming logic; emits one parallel frame record per good frame.

Parameters:
- CLKS_PER_BIT, 10, i_Clock cycles per CAN bit; must be >= 4.
- SAMPLE_PT, 7, counter value within a bit at which the bus is sampled; 0 < SAMPLE_PT < CLKS_PER_BIT.
- EXT_ID_EN, 1, 1 = accept extended (IDE=1) frames; 0 = silently discard them.

Ports:
- i_Clock  in  1  system clock.
- i_Reset_n  in  1  reset; synchronous, active-low.
- i_Rx_Serial  in  1  raw bus level; 0 = dominant.
- o_Rx_DV  out  1  one-cycle pulse: frame fields below are valid.
- o_Rx_Id  out  29  identifier; standard ID in [10:0] with [28:11]=0; extended ID as base[28:18] and ext[17:0].
- o_Rx_Ide  out  1  1 = extended frame.
- o_Rx_Rtr  out  1  1 = remote frame.
- o_Rx_Dlc  out  4  raw DLC as received (0-15).
- o_Rx_Data  out  64  byte k in [8k+7:8k]; byte 0 is the first received byte; MSB first within each byte; unused bytes are 0.
- o_Rx_Err  out  1  one-cycle pulse: frame aborted.
- o_Rx_Err_Code  out  3  {crc, stuff, form}; valid with o_Rx_Err.
- o_Busy  out  1  high from SOF until a frame ends or aborts.

Behaviour:
- Input path: i_Rx_Serial is double-registered; all logic below uses the second stage.
- Reset (i_Reset_n=0 on a clock edge):
  - All outputs go to 0 and the state goes to INTEGRATE, including when reset arrives mid-frame.
  - No DV or Err pulse is produced for a frame aborted by reset.
- INTEGRATE: count consecutive recessive samples, one per bit period (free-running bit counter). After 11, go to IDLE. Any dominant sample restarts the count.
- IDLE: a registered 0 performs a hard sync: bit counter := 0, state := SOF.
- Bit counter: runs 0..CLKS_PER_BIT-1 and wraps. Sampling happens only when counter==SAMPLE_PT. There is no resynchronisation within a frame.
- SOF: if the sample is recessive, treat it as a glitch and return to IDLE with no error. Otherwise enter ARB.
- Destuffing:
  - Applies from SOF through the last CRC bit.
  - After 5 consecutive equal samples, the next sample is a stuff bit. It is discarded and does not count toward any field.
  - A stuff bit equal to the previous bit is a stuff error.
  - The stuff run counter restarts with the stuff bit's value.
- Field sequence (destuffed bits, MSB first):
  - ID_A: 11 bits, then SRR/RTR, then IDE.
  - IDE=0: r0, then DLC(4).
  - IDE=1: ID_B(18), RTR, r1, r0, then DLC(4).
  - IDE=1 with EXT_ID_EN=0: go to INTEGRATE, no pulse.
- DATA: 8*min(DLC,8) bits. Skipped when RTR=1 or DLC=0.
- CRC:
  - 15 bits, compared with CRC-15 (polynomial 0x4599, init 0) computed over destuffed bits from SOF through the end of DATA.
  - A mismatch sets crc_err, which is evaluated at the CRC delimiter.
- CRC_DEL: must be recessive, else form error.
- ACK: sampled and ignored; the block never drives the bus.
- ACK_DEL: must be recessive, else form error.
- EOF: 7 samples, all must be recessive. A dominant sample is a form error.
- Frame end:
  - On the clock after the 7th EOF sample, if crc_err=0: o_Rx_DV=1 for one cycle and all frame outputs update on that same edge.
  - If crc_err=1: o_Rx_Err=1 with code 3'b100 instead.
  - Then return to IDLE.
- Error abort:
  - On the clock after the offending sample: o_Rx_Err=1 for one cycle with exactly one code bit set (priority stuff > form > crc). Frame outputs are unchanged.
  - State goes to INTEGRATE.
- Output holding: frame outputs hold their values until the next DV. A DV and an Err pulse are never asserted in the same cycle.
- o_Busy: 1 from SOF entry until the DV/Err cycle, inclusive.

Test Plan:
- Standard frame, ID 0x123, DLC 2, data AB CD, bench-computed CRC, correctly stuffed -> single DV pulse; o_Rx_Id=0x123, o_Rx_Ide=0, o_Rx_Rtr=0, o_Rx_Dlc=2, o_Rx_Data=0x...0000CDAB; no Err.
- Extended remote frame, ID 0x1ABCDE12, RTR=1, DLC 4 -> DV with o_Rx_Ide=1, o_Rx_Rtr=1, o_Rx_Dlc=4, o_Rx_Data=0. Repeat with EXT_ID_EN=0 -> neither DV nor Err.
- Frame with DLC 15 and 8 data bytes 01..08 -> o_Rx_Dlc=15, o_Rx_Data=0x0807060504030201.
- Six consecutive dominant bits injected inside the ID (no stuff bit) -> o_Rx_Err pulse with code 3'b010; no DV. A following valid frame, sent after 11 recessive bits, is received normally.
- One CRC bit flipped (restuffed) -> Err with code 3'b100. Dominant CRC delimiter -> code 3'b001. Dominant 3rd EOF bit -> code 3'b001.
- i_Reset_n low for 1 cycle during DATA -> all outputs 0 on the next edge. A frame starting after only 5 recessive bits is ignored. A frame starting after 11 or more recessive bits gives DV. A 3-clock dominant glitch in IDLE (CLKS_PER_BIT=10) -> no pulse.
